// File: rtl/color_scan_ctrl.sv
// Colour sensor scan sequencer: steps the filter through red, green and blue,
// counts sensor pulses per channel and publishes the dominant colour.
module color_scan_ctrl #(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 500,
    parameter int CNT_W         = 16,
    parameter int MIN_CNT       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sensor_out,
    output logic             s2,
    output logic             s3,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [2:0]       color,
    output logic             data_set_done,
    output logic             busy
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W:0]   MIN_EXT     = (CNT_W + 1)'(MIN_CNT);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_COUNT  = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       sync_reg;
    logic             edge_reg;
    logic [2:0]       state_reg;
    logic [1:0]       ch_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [CNT_W-1:0] work_cnt_reg;
    logic [CNT_W-1:0] red_res_reg;
    logic [CNT_W-1:0] green_res_reg;
    logic [CNT_W-1:0] red_cnt_reg;
    logic [CNT_W-1:0] green_cnt_reg;
    logic [CNT_W-1:0] blue_cnt_reg;
    logic [2:0]       color_reg;
    logic             s2_reg;
    logic             s3_reg;
    logic             dsd_reg;
    logic             busy_reg;

    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       color_next;
    logic             abort;

    // Saturating increment; also used to fold in a pulse landing on the final gate cycle.
    always_comb begin
        cnt_next = work_cnt_reg;
        if (edge_reg && !(&work_cnt_reg)) begin
            cnt_next = work_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        color_next = 3'd0;
        if (red_cnt_reg > green_cnt_reg && red_cnt_reg > blue_cnt_reg &&
            {1'b0, red_cnt_reg} >= MIN_EXT) begin
            color_next = 3'd1;
        end else if (green_cnt_reg > red_cnt_reg && green_cnt_reg > blue_cnt_reg &&
                     {1'b0, green_cnt_reg} >= MIN_EXT) begin
            color_next = 3'd2;
        end else if (blue_cnt_reg > red_cnt_reg && blue_cnt_reg > green_cnt_reg &&
                     {1'b0, blue_cnt_reg} >= MIN_EXT) begin
            color_next = 3'd3;
        end
    end

    assign abort = !enable &&
                   (state_reg == ST_SETTLE || state_reg == ST_COUNT || state_reg == ST_DECIDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg      <= '0;
            edge_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
            ch_reg        <= 2'd0;
            timer_reg     <= '0;
            work_cnt_reg  <= '0;
            red_res_reg   <= '0;
            green_res_reg <= '0;
            red_cnt_reg   <= '0;
            green_cnt_reg <= '0;
            blue_cnt_reg  <= '0;
            color_reg     <= 3'd0;
            s2_reg        <= 1'b0;
            s3_reg        <= 1'b0;
            dsd_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], sensor_out};
            edge_reg <= sync_reg[1] & ~sync_reg[2];
            dsd_reg  <= 1'b0;
            if (abort) begin
                // Partial results stay in the scratch registers and are never published.
                state_reg <= ST_IDLE;
                ch_reg    <= 2'd0;
                timer_reg <= '0;
                s2_reg    <= 1'b0;
                s3_reg    <= 1'b0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (enable) begin
                            state_reg    <= ST_SETTLE;
                            ch_reg       <= 2'd0;
                            timer_reg    <= '0;
                            work_cnt_reg <= '0;
                            s2_reg       <= 1'b0;
                            s3_reg       <= 1'b0;
                            busy_reg     <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_reg == SETTLE_LAST) begin
                            timer_reg    <= '0;
                            work_cnt_reg <= '0;
                            state_reg    <= ST_COUNT;
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end
                    ST_COUNT: begin
                        work_cnt_reg <= cnt_next;
                        if (timer_reg == GATE_LAST) begin
                            timer_reg <= '0;
                            case (ch_reg)
                                2'd0: begin
                                    red_res_reg <= cnt_next;
                                    ch_reg      <= 2'd1;
                                    s2_reg      <= 1'b1;
                                    s3_reg      <= 1'b1;
                                    state_reg   <= ST_SETTLE;
                                end
                                2'd1: begin
                                    green_res_reg <= cnt_next;
                                    ch_reg        <= 2'd2;
                                    s2_reg        <= 1'b0;
                                    s3_reg        <= 1'b1;
                                    state_reg     <= ST_SETTLE;
                                end
                                default: begin
                                    red_cnt_reg   <= red_res_reg;
                                    green_cnt_reg <= green_res_reg;
                                    blue_cnt_reg  <= cnt_next;
                                    state_reg     <= ST_DECIDE;
                                end
                            endcase
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end
                    ST_DECIDE: begin
                        color_reg <= color_next;
                        dsd_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                    ST_DONE: begin
                        ch_reg    <= 2'd0;
                        timer_reg <= '0;
                        s2_reg    <= 1'b0;
                        s3_reg    <= 1'b0;
                        if (enable) begin
                            work_cnt_reg <= '0;
                            state_reg    <= ST_SETTLE;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s2            = s2_reg;
    assign s3            = s3_reg;
    assign red_cnt       = red_cnt_reg;
    assign green_cnt     = green_cnt_reg;
    assign blue_cnt      = blue_cnt_reg;
    assign color         = color_reg;
    assign data_set_done = dsd_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// Bench for color_scan_ctrl: scan-level model checked every cycle plus
// hand-computed literal expectations for each directed scenario.
module tb_color_scan_ctrl;

    localparam int G     = 100;
    localparam int S     = 10;
    localparam int W     = 16;
    localparam int MINC  = 4;
    localparam int SCAN  = 3 * (S + G) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable_a = 1'b0, sensor_a = 1'b0;
    logic          s2_a, s3_a, dsd_a, busy_a;
    logic [W-1:0]  red_a, green_a, blue_a;
    logic [2:0]    color_a;
    logic          enable_b = 1'b0, sensor_b = 1'b0;
    logic          s2_b, s3_b, dsd_b, busy_b;
    logic [3:0]    red_b, green_b, blue_b;
    logic [2:0]    color_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int per_a [3];
    int per_b [3];

    color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W), .MIN_CNT(MINC)) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .sensor_out(sensor_a),
        .s2(s2_a), .s3(s3_a), .red_cnt(red_a), .green_cnt(green_a), .blue_cnt(blue_a),
        .color(color_a), .data_set_done(dsd_a), .busy(busy_a)
    );

    color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4), .MIN_CNT(MINC)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .sensor_out(sensor_b),
        .s2(s2_b), .s3(s3_b), .red_cnt(red_b), .green_cnt(green_b), .blue_cnt(blue_b),
        .color(color_b), .data_set_done(dsd_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d..%0d", name, cyc, act, lo, hi);
        end
    endtask

    function automatic int chan_of(input logic a, input logic b);
        if ({a, b} == 2'b00) return 0;
        if ({a, b} == 2'b11) return 1;
        if ({a, b} == 2'b01) return 2;
        return 3;
    endfunction

    // Square wave whose period follows the selected filter; phase restarts at each channel start.
    initial begin : gen_a
        logic [2:0] key_prev;
        int phase, per, c;
        key_prev = 3'b000;
        phase = 0;
        forever begin
            @(posedge clk); #1;
            if ({busy_a, s2_a, s3_a} != key_prev) phase = 0; else phase++;
            key_prev = {busy_a, s2_a, s3_a};
            c = chan_of(s2_a, s3_a);
            per = (c < 3) ? per_a[c] : 0;
            sensor_a = (per != 0) && ((phase % per) < per / 2);
        end
    end

    initial begin : gen_b
        logic [2:0] key_prev;
        int phase, per, c;
        key_prev = 3'b000;
        phase = 0;
        forever begin
            @(posedge clk); #1;
            if ({busy_b, s2_b, s3_b} != key_prev) phase = 0; else phase++;
            key_prev = {busy_b, s2_b, s3_b};
            c = chan_of(s2_b, s3_b);
            per = (c < 3) ? per_b[c] : 0;
            sensor_b = (per != 0) && ((phase % per) < per / 2);
        end
    end

    // Scan-level model of dut_a: a scan is a time window starting at t0; counts come
    // from the logged pin rises whose pulse (3 cycles later) falls in a gate window.
    int rises [$];
    int m_cnt [3];
    int m_color = 0;

    function automatic int window_count(input int t0, input int c);
        int lo, hi, n;
        lo = t0 + c * (S + G) + S;
        hi = lo + G - 1;
        n = 0;
        foreach (rises[i]) if (rises[i] + 3 >= lo && rises[i] + 3 <= hi) n++;
        if (n > (1 << W) - 1) n = (1 << W) - 1;
        return n;
    endfunction

    initial begin : model
        bit run, en_prev, rst_prev, pin_prev;
        int n, p, t0, mx, nmx, idx, code;
        run = 0; en_prev = 0; rst_prev = 1; pin_prev = 0; t0 = 0; p = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        forever begin
            @(negedge clk);
            n = cyc;
            if (rst) begin
                run = 0;
                foreach (m_cnt[i]) m_cnt[i] = 0;
                m_color = 0;
            end else begin
                if (rst_prev) run = 0;
                else if (!run) begin
                    if (en_prev) begin run = 1; t0 = n; end
                end else if (n - 1 - t0 == SCAN - 1) begin
                    if (en_prev) t0 = n; else run = 0;
                end else if (!en_prev) run = 0;
                if (run) begin
                    p = n - t0;
                    if (p == SCAN - 2) for (int c = 0; c < 3; c++) m_cnt[c] = window_count(t0, c);
                    if (p == SCAN - 1) begin
                        mx = -1; nmx = 0; idx = 0;
                        for (int c = 0; c < 3; c++) begin
                            if (m_cnt[c] > mx) begin mx = m_cnt[c]; nmx = 1; idx = c; end
                            else if (m_cnt[c] == mx) nmx++;
                        end
                        m_color = (nmx == 1 && mx >= MINC) ? idx + 1 : 0;
                    end
                end
            end
            chk("busy", busy_a, run);
            chk("dsd", dsd_a, run && (n - t0 == SCAN - 1));
            chk("red_cnt", red_a, m_cnt[0]);
            chk("green_cnt", green_a, m_cnt[1]);
            chk("blue_cnt", blue_a, m_cnt[2]);
            chk("color", color_a, m_color);
            if (!run) chk("s2s3_idle", {s2_a, s3_a}, 0);
            else if (n - t0 < SCAN - 2) begin
                code = ((n - t0) / (S + G) == 0) ? 0 : ((n - t0) / (S + G) == 1) ? 3 : 1;
                chk("s2s3", {s2_a, s3_a}, code);
            end
            if (sensor_a && !pin_prev) rises.push_back(n);
            pin_prev = sensor_a; en_prev = enable_a; rst_prev = rst;
        end
    end

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic wait_dsd(input bit use_b, output int at);
        at = -1;
        for (int i = 0; i < 2 * SCAN; i++) begin
            @(posedge clk); #1;
            if (use_b ? dsd_b : dsd_a) begin at = cyc; return; end
        end
        chk("dsd_wait_timeout", 0, 1);
    endtask

    initial begin : stim
        int e, d, d1, d2, d3, seen;
        per_a = '{0, 0, 0};
        per_b = '{0, 0, 0};
        tick(3);
        chk("rst_busy", busy_a, 0);
        chk("rst_color", color_a, 0);
        chk("rst_dsd", dsd_a, 0);
        rst = 1'b0;
        tick(2);

        // Red dominant: 25 / 10 / 10 pulses.
        per_a = '{4, 10, 10};
        enable_a = 1'b1; e = cyc;
        wait_dsd(0, d);
        chk("red_latency", d - e, SCAN);
        chk_range("red_red", red_a, 24, 26);
        chk_range("red_green", green_a, 9, 11);
        chk_range("red_blue", blue_a, 9, 11);
        chk("red_color", color_a, 1);
        tick(1);
        chk("red_dsd_single", dsd_a, 0);

        // Reset in the middle of the next scan's red COUNT window.
        tick(48);
        rst = 1'b1; #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_color", color_a, 0);
        chk("mid_rst_red", red_a, 0);
        chk("mid_rst_s2s3", {s2_a, s3_a}, 0);
        tick(3);
        rst = 1'b0; e = cyc;
        wait_dsd(0, d);
        chk("post_rst_latency", d - e, SCAN);
        chk("post_rst_color", color_a, 1);
        tick(1);
        enable_a = 1'b0;

        // Tie: equal period everywhere.
        tick(5);
        per_a = '{8, 8, 8};
        enable_a = 1'b1; e = cyc;
        wait_dsd(0, d);
        chk("tie_red", red_a, 13);
        chk("tie_blue", blue_a, 13);
        chk("tie_color", color_a, 0);
        tick(1);
        enable_a = 1'b0;

        // No pulses at all: still a result strobe.
        tick(5);
        per_a = '{0, 0, 0};
        enable_a = 1'b1; e = cyc;
        wait_dsd(0, d);
        chk("zero_latency", d - e, SCAN);
        chk("zero_red", red_a, 0);
        chk("zero_color", color_a, 0);
        tick(1);
        enable_a = 1'b0;

        // Continuous run, blue dominant.
        tick(5);
        per_a = '{0, 0, 5};
        enable_a = 1'b1; e = cyc;
        wait_dsd(0, d1);
        chk("cont_blue", blue_a, 20);
        chk("cont_color1", color_a, 3);
        wait_dsd(0, d2);
        chk("cont_gap1", d2 - d1, SCAN);
        chk("cont_color2", color_a, 3);
        wait_dsd(0, d3);
        chk("cont_gap2", d3 - d2, SCAN);
        chk("cont_color3", color_a, 3);
        tick(1);
        enable_a = 1'b0;

        // Abort during green COUNT: prior results must survive.
        tick(5);
        per_a = '{6, 6, 0};
        enable_a = 1'b1; e = cyc;
        tick(151);
        enable_a = 1'b0;
        tick(1);
        chk("abort_busy", busy_a, 0);
        chk("abort_s2s3", {s2_a, s3_a}, 0);
        chk("abort_color", color_a, 3);
        chk("abort_blue", blue_a, 20);
        chk("abort_red", red_a, 0);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (dsd_a) seen++;
        end
        chk("abort_no_dsd", seen, 0);

        // Saturation on the narrow-counter instance.
        per_b = '{0, 0, 2};
        enable_b = 1'b1; e = cyc;
        wait_dsd(1, d);
        chk("sat_latency", d - e, SCAN);
        chk("sat_blue", blue_b, 15);
        chk("sat_red", red_b, 0);
        chk("sat_green", green_b, 0);
        chk("sat_color", color_b, 3);
        tick(1);
        enable_b = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
